// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Imported by fetch_unit; sits alongside processor_defines.sv.
`timescale 1ns/1ps
package fetch_unit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RSP,
      HOLD,
      DRAIN,
      HALT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int          ILEN_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem requests,
// valid/ready handoff to decode, and redirect handling with stale-fetch drain.
// Optional build macro FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned output
// and a HALT state entered on a misaligned redirect target.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | request for pc offered to imem (unless redirecting)
// WAIT_RSP | request accepted, waiting for the instruction word
// HOLD     | instruction presented to decode, waiting for id_ready
// DRAIN    | redirected while a request is outstanding; drop its response
// HALT     | misaligned redirect trapped; idle until an aligned redirect
`timescale 1ns/1ps
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] instruction_code,
   output logic [XLEN-1:0] pc_out
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_misaligned
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d;
   logic            out_of_reset_q;
   logic [XLEN-1:0] redir_target;

   // The PC register never holds a non-word address; low bits are dropped here.
   assign redir_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned_q, misaligned_d;
   logic redir_misaligned;

   assign redir_misaligned = |redirect_pc[1:0];
   assign fetch_misaligned = misaligned_q;
`else
   logic unused_redir_lsb;

   assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

   // Request only from IDLE, never in the redirect cycle, and not until one
   // clock after reset release.
   assign imem_req_valid   = (state_q == IDLE) && out_of_reset_q && !redirect_valid;
   assign imem_addr        = {pc_q[XLEN-1:2], 2'b00};
   assign if_valid         = if_valid_q;
   assign instruction_code = instr_q;
   assign pc_out           = pc_out_q;

   // Next-state and datapath; redirect overrides every state.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_d = misaligned_q;
`endif
      if (redirect_valid) begin
         pc_d       = redir_target;
         if_valid_d = 1'b0;
         if ((state_q == WAIT_RSP || state_q == DRAIN) && !imem_rsp_valid) begin
            state_d = DRAIN;
         end else begin
            state_d = IDLE;
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         misaligned_d = redir_misaligned;
         if (redir_misaligned) begin
            state_d = HALT;
         end
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (imem_req_valid && imem_req_ready) begin
                  state_d = WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (imem_rsp_valid) begin
                  instr_d    = imem_rsp_data;
                  pc_out_d   = pc_q;
                  if_valid_d = 1'b1;
                  pc_d       = pc_q + XLEN'(ILEN_BYTES);
                  state_d    = HOLD;
               end
            end
            HOLD: begin
               if (id_ready) begin
                  if_valid_d = 1'b0;
                  state_d    = IDLE;
               end
            end
            DRAIN: begin
               if (imem_rsp_valid) begin
                  state_d = IDLE;
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, PC and decode-facing holding registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         pc_q           <= RESET_PC;
         if_valid_q     <= 1'b0;
         instr_q        <= NOP_INSTR;
         pc_out_q       <= '0;
         out_of_reset_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misaligned_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         if_valid_q     <= if_valid_d;
         instr_q        <= instr_d;
         pc_out_q       <= pc_out_d;
         out_of_reset_q <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
         misaligned_q   <= misaligned_d;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-configurable imem model.
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] instruction_code;
   logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misaligned;
`endif

   int checks   = 0;
   int failures = 0;

   // imem model controls
   int          lat;
   logic        ovr_en;
   logic [31:0] ovr_data;
   logic        acc;
   logic [31:0] acc_addr;
   logic        pend;
   int          cnt;
   logic [31:0] pdata;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_addr        (imem_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .if_valid         (if_valid),
      .id_ready         (id_ready),
      .instruction_code (instruction_code),
      .pc_out           (pc_out)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0000_0537;
      return {16'hC0DE, a[15:0]};
   endfunction

   // imem model: acceptance seen at the negedge before the edge, response
   // driven 1ns after an edge, sampled by the DUT lat edges after acceptance.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      pend           = 1'b0;
      cnt            = 0;
      pdata          = 32'h0;
      forever begin
         @(negedge clk);
         acc      = imem_req_valid && imem_req_ready;
         acc_addr = imem_addr;
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         if (acc) begin
            pend  = 1'b1;
            cnt   = lat;
            pdata = ovr_en ? ovr_data : mem_word(acc_addr);
         end
         if (pend) begin
            if (cnt <= 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = pdata;
               pend           = 1'b0;
            end else begin
               cnt = cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst_n          = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      lat            = 1;
      ovr_en         = 1'b0;
      ovr_data       = 32'h0;
      #1 rst_n = 1'b0;

      // reset values
      tick(); smp();
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_instr", instruction_code, 32'h0000_0013);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_addr", imem_addr, 32'h0000_0100);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("rst_misaligned", 32'(fetch_misaligned), 32'h0);
`endif

      // release: request gated for one cycle
      tick(); rst_n = 1'b1; smp();
      chk("req_gated_after_rst", 32'(imem_req_valid), 32'h0);
      tick(); smp();
      chk("first_req_valid", 32'(imem_req_valid), 32'h1);
      chk("first_addr", imem_addr, 32'h0000_0100);
      tick(); smp();
      chk("wait_req_low", 32'(imem_req_valid), 32'h0);
      chk("wait_if_valid", 32'(if_valid), 32'h0);
      tick(); smp();
      chk("hold_if_valid", 32'(if_valid), 32'h1);
      chk("hold_instr", instruction_code, 32'h0000_0537);
      chk("hold_pc_out", pc_out, 32'h0000_0100);
      chk("hold_addr_next", imem_addr, 32'h0000_0104);

      // stall in HOLD
      for (int i = 0; i < 5; i++) begin
         tick(); smp();
         chk("stall_if_valid", 32'(if_valid), 32'h1);
         chk("stall_instr", instruction_code, 32'h0000_0537);
         chk("stall_pc_out", pc_out, 32'h0000_0100);
         chk("stall_req_low", 32'(imem_req_valid), 32'h0);
      end
      tick(); id_ready = 1'b1; smp();
      chk("ready_same_cycle_if_valid", 32'(if_valid), 32'h1);
      tick(); id_ready = 1'b0; lat = 2; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; smp();
      chk("handoff_if_valid", 32'(if_valid), 32'h0);
      chk("handoff_req_valid", 32'(imem_req_valid), 32'h1);
      chk("handoff_addr", imem_addr, 32'h0000_0104);

      // redirect while WAIT_RSP, response arrives in DRAIN
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; smp();
      chk("wait2_req_low", 32'(imem_req_valid), 32'h0);
      tick(); redirect_valid = 1'b0; smp();
      chk("drain_req_low", 32'(imem_req_valid), 32'h0);
      chk("drain_if_valid", 32'(if_valid), 32'h0);
      chk("drain_addr", imem_addr, 32'h0000_0200);
      tick(); ovr_en = 1'b0; lat = 1; smp();
      chk("dropped_if_valid", 32'(if_valid), 32'h0);
      chk("dropped_instr", instruction_code, 32'h0000_0537);
      chk("redir_req_valid", 32'(imem_req_valid), 32'h1);
      chk("redir_addr", imem_addr, 32'h0000_0200);

      // redirect in HOLD with id_ready the same cycle
      tick(); smp();
      chk("wait3_if_valid", 32'(if_valid), 32'h0);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; id_ready = 1'b1; smp();
      chk("hold2_if_valid", 32'(if_valid), 32'h1);
      chk("hold2_instr", instruction_code, 32'hC0DE_0200);
      chk("hold2_pc_out", pc_out, 32'h0000_0200);
      tick(); redirect_pc = 32'hFFFF_FFFC; id_ready = 1'b0; smp();
      chk("killed_if_valid", 32'(if_valid), 32'h0);
      chk("idle_redirect_masks_req", 32'(imem_req_valid), 32'h0);
      chk("kill_addr", imem_addr, 32'h0000_0300);

      // wrap at top of address space
      tick(); redirect_valid = 1'b0; smp();
      chk("top_req_valid", 32'(imem_req_valid), 32'h1);
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      tick(); smp();
      tick(); id_ready = 1'b1; smp();
      chk("top_if_valid", 32'(if_valid), 32'h1);
      chk("top_instr", instruction_code, 32'hC0DE_FFFC);
      chk("top_pc_out", pc_out, 32'hFFFF_FFFC);
      tick(); id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0202; smp();
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      chk("wrap_if_valid", 32'(if_valid), 32'h0);

      // misaligned redirect target
      tick(); redirect_valid = 1'b0; smp();
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("trap_flag_set", 32'(fetch_misaligned), 32'h1);
      chk("trap_req_low", 32'(imem_req_valid), 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick(); smp();
         chk("halt_req_low", 32'(imem_req_valid), 32'h0);
         chk("halt_if_valid", 32'(if_valid), 32'h0);
      end
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; smp();
      chk("halt_redirect_req_low", 32'(imem_req_valid), 32'h0);
      tick(); redirect_valid = 1'b0; smp();
      chk("trap_flag_clear", 32'(fetch_misaligned), 32'h0);
      chk("resume_req_valid", 32'(imem_req_valid), 32'h1);
      chk("resume_addr", imem_addr, 32'h0000_0300);
`else
      chk("align_req_valid", 32'(imem_req_valid), 32'h1);
      chk("align_addr", imem_addr, 32'h0000_0200);
`endif

      // reset while a request is outstanding; late response must be ignored
      tick(); rst_n = 1'b0; smp();
      chk("midrst_if_valid", 32'(if_valid), 32'h0);
      chk("midrst_instr", instruction_code, 32'h0000_0013);
      chk("midrst_pc_out", pc_out, 32'h0);
      chk("midrst_addr", imem_addr, 32'h0000_0100);
      chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
      tick(); rst_n = 1'b1; smp();
      chk("postrst_req_gated", 32'(imem_req_valid), 32'h0);
      chk("postrst_if_valid", 32'(if_valid), 32'h0);
      tick(); smp();
      chk("postrst_req_valid", 32'(imem_req_valid), 32'h1);
      chk("postrst_addr", imem_addr, 32'h0000_0100);
      chk("postrst_late_rsp_ignored", 32'(if_valid), 32'h0);
      tick(); smp();
      tick(); smp();
      chk("postrst_if_valid_hold", 32'(if_valid), 32'h1);
      chk("postrst_instr", instruction_code, 32'h0000_0537);
      chk("postrst_pc_out", pc_out, 32'h0000_0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
